// File: rtl/mag_cmp_pkg.sv
// rtl/mag_cmp_pkg.sv - shared types and sizing helpers for the iterative magnitude comparator
package mag_cmp_pkg;

    typedef enum logic [1:0] {
        IDL = 2'd0,
        CMP = 2'd1,
        RSP = 2'd2
    } state_t;

    // Number of digit steps needed to cover a width, rounding up.
    function automatic int steps(input int width, input int digit);
        return (width + digit - 1) / digit;
    endfunction

    // Step counter width; at least one bit even for a single step.
    function automatic int cnt_width(input int nsteps);
        return (nsteps <= 1) ? 1 : $clog2(nsteps);
    endfunction

endpackage

// File: rtl/mag_cmp_base.sv
// rtl/mag_cmp_base.sv - combinational unsigned magnitude compare of one digit
module mag_cmp_base #(
    parameter int WIDTH          = 8,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             grt,
    output logic             lst
);

    generate
        if (IMPLEMENTATION == 0) begin : g_rel
            assign grt = (a > b);
            assign lst = (a < b);
        end else begin : g_sub
            // Borrow out of a-b means a<b; a nonzero difference without borrow means a>b.
            logic [WIDTH:0] diff;
            assign diff = {1'b0, a} - {1'b0, b};
            assign lst  = diff[WIDTH];
            assign grt  = !diff[WIDTH] && (diff[WIDTH-1:0] != '0);
        end
    endgenerate

endmodule

// File: rtl/mag_cmp_seq.sv
// rtl/mag_cmp_seq.sv - digit-serial magnitude comparator, MSB digit first; MAG_CMP_SEQ_EARLY_EN enables early exit
module mag_cmp_seq
    import mag_cmp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGIT  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [WIDTH-1:0] val,
    input  logic [WIDTH-1:0] rfr,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic             grt,
    output logic             lst,
    output logic             equ
);

    localparam int STEPS = steps(WIDTH, DIGIT);
    localparam int PW    = STEPS * DIGIT;
    localparam int CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] CNT_LOAD = CW'(STEPS - 1);

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   sh_val;
    logic [PW-1:0]   sh_rfr;
    logic [PW-1:0]   cap_val;
    logic [PW-1:0]   cap_rfr;
    logic [CW-1:0]   cnt;
    logic            dig_grt;
    logic            dig_lst;
    logic            dig_equ;
    logic            req_acc;
    logic            last_step;

`ifndef MAG_CMP_SEQ_EARLY_EN
    logic            hit;
    logic            hit_grt;
`endif

    // Zero-pad on the MSB side; in signed mode flip the sign bit to get offset binary.
    always_comb begin
        cap_val              = '0;
        cap_rfr              = '0;
        cap_val[WIDTH-1:0]   = val;
        cap_rfr[WIDTH-1:0]   = rfr;
        if (SIGNED != 0) begin
            cap_val[WIDTH-1] = ~val[WIDTH-1];
            cap_rfr[WIDTH-1] = ~rfr[WIDTH-1];
        end
    end

    mag_cmp_base #(
        .WIDTH          (DIGIT),
        .IMPLEMENTATION (0)
    ) u_digit (
        .a   (sh_val[PW-1 -: DIGIT]),
        .b   (sh_rfr[PW-1 -: DIGIT]),
        .grt (dig_grt),
        .lst (dig_lst)
    );

    assign dig_equ   = !dig_grt && !dig_lst;
    assign last_step = (cnt == '0);
    assign req_acc   = req_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_rdy   = 1'b0;
        rsp_vld   = 1'b0;
        case (state)
            IDL: begin
                req_rdy = 1'b1;
                if (req_acc) begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
`ifdef MAG_CMP_SEQ_EARLY_EN
                if (!dig_equ || last_step) begin
                    state_nxt = RSP;
                end
`else
                if (last_step) begin
                    state_nxt = RSP;
                end
`endif
            end
            RSP: begin
                rsp_vld = 1'b1;
                if (rsp_rdy) begin
                    state_nxt = IDL;
                end
            end
            default: begin
                state_nxt = IDL;
            end
        endcase
    end

    // Operand shifters hold no meaningful state outside an operation, so they are not reset.
    always_ff @(posedge clk) begin
        if (state == IDL && req_acc) begin
            sh_val <= cap_val;
            sh_rfr <= cap_rfr;
        end else if (state == CMP) begin
            sh_val <= sh_val << DIGIT;
            sh_rfr <= sh_rfr << DIGIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            grt     <= 1'b0;
            lst     <= 1'b0;
            equ     <= 1'b0;
`ifndef MAG_CMP_SEQ_EARLY_EN
            hit     <= 1'b0;
            hit_grt <= 1'b0;
`endif
        end else begin
            case (state)
                IDL: begin
                    if (req_acc) begin
                        cnt     <= CNT_LOAD;
`ifndef MAG_CMP_SEQ_EARLY_EN
                        hit     <= 1'b0;
                        hit_grt <= 1'b0;
`endif
                    end
                end
                CMP: begin
`ifdef MAG_CMP_SEQ_EARLY_EN
                    if (!dig_equ || last_step) begin
                        grt <= dig_grt;
                        lst <= dig_lst;
                        equ <= dig_equ;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
`else
                    // Only the most significant differing digit decides; later digits are ignored.
                    if (!hit && !dig_equ) begin
                        hit     <= 1'b1;
                        hit_grt <= dig_grt;
                    end
                    if (last_step) begin
                        grt <= hit ? hit_grt  : dig_grt;
                        lst <= hit ? !hit_grt : dig_lst;
                        equ <= !hit && dig_equ;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
`endif
                end
                RSP: begin
                    if (rsp_rdy) begin
                        grt <= 1'b0;
                        lst <= 1'b0;
                        equ <= 1'b0;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mag_cmp_seq.sv
// tb/tb_mag_cmp_seq.sv - scoreboard bench for mag_cmp_seq over unsigned, signed and padded configurations
module tb_mag_cmp_seq;

    localparam int ND = 3;
    localparam int W  [ND] = '{32, 32, 12};
    localparam int DG [ND] = '{8, 8, 8};
    localparam int SG [ND] = '{0, 1, 0};

    typedef struct {
        logic [2:0] fl;
        int         k;
        int         acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_vld [ND];
    logic        req_rdy [ND];
    logic [31:0] val     [ND];
    logic [31:0] rfr     [ND];
    logic        rsp_vld [ND];
    logic        rsp_rdy [ND];
    logic        grt     [ND];
    logic        lst     [ND];
    logic        equ     [ND];

    exp_t        q       [ND][$];
    exp_t        cur     [ND];
    bit          seen    [ND];
    bit          hold    [ND];
    bit          bp_en   [ND];
    int          cyc;
    int          n_chk;
    int          n_fail;

    mag_cmp_seq #(.WIDTH(32), .DIGIT(8), .SIGNED(0)) u_u32 (
        .clk(clk), .rst(rst), .req_vld(req_vld[0]), .req_rdy(req_rdy[0]),
        .val(val[0]), .rfr(rfr[0]), .rsp_vld(rsp_vld[0]), .rsp_rdy(rsp_rdy[0]),
        .grt(grt[0]), .lst(lst[0]), .equ(equ[0]));

    mag_cmp_seq #(.WIDTH(32), .DIGIT(8), .SIGNED(1)) u_s32 (
        .clk(clk), .rst(rst), .req_vld(req_vld[1]), .req_rdy(req_rdy[1]),
        .val(val[1]), .rfr(rfr[1]), .rsp_vld(rsp_vld[1]), .rsp_rdy(rsp_rdy[1]),
        .grt(grt[1]), .lst(lst[1]), .equ(equ[1]));

    mag_cmp_seq #(.WIDTH(12), .DIGIT(8), .SIGNED(0)) u_u12 (
        .clk(clk), .rst(rst), .req_vld(req_vld[2]), .req_rdy(req_rdy[2]),
        .val(val[2][11:0]), .rfr(rfr[2][11:0]), .rsp_vld(rsp_vld[2]), .rsp_rdy(rsp_rdy[2]),
        .grt(grt[2]), .lst(lst[2]), .equ(equ[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h want %0h", nm, d, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer compare, latency from the first differing padded digit.
    function automatic void model(input int d, input logic [31:0] v, input logic [31:0] r,
                                  output logic [2:0] fl, output int k);
        int     st;
        longint mv, mr, dm, half;
        bit     found;
        st   = (W[d] + DG[d] - 1) / DG[d];
        mv   = longint'(v) & ((64'sd1 << W[d]) - 1);
        mr   = longint'(r) & ((64'sd1 << W[d]) - 1);
        half = 64'sd1 << (W[d] - 1);
        if (SG[d] != 0) begin
            if (mv >= half) mv = mv - 2 * half;
            if (mr >= half) mr = mr - 2 * half;
        end
        fl = {mv > mr, mv < mr, mv == mr};
        if (SG[d] != 0) begin
            mv = mv + half;
            mr = mr + half;
        end
        dm    = (64'sd1 << DG[d]) - 1;
        k     = st;
        found = 0;
        for (int i = 0; i < st; i++) begin
            if (!found && (((mv >> ((st - 1 - i) * DG[d])) & dm) != ((mr >> ((st - 1 - i) * DG[d])) & dm))) begin
                found = 1;
                k     = i + 1;
            end
        end
`ifndef MAG_CMP_SEQ_EARLY_EN
        k = st;
`endif
    endfunction

    task automatic issue(input int d, input logic [31:0] v, input logic [31:0] r);
        int   n;
        exp_t e;
        n = 0;
        while (!req_rdy[d] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_rdy[d]) begin
            chk("req_rdy_timeout", d, 32'(req_rdy[d]), 32'd1);
            return;
        end
        val[d]     = v;
        rfr[d]     = r;
        req_vld[d] = 1'b1;
        @(posedge clk); #1;
        req_vld[d] = 1'b0;
        val[d]     = $urandom;
        rfr[d]     = $urandom;
        model(d, v, r, e.fl, e.k);
        e.acc = cyc;
        q[d].push_back(e);
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while ((q[d].size() != 0 || !req_rdy[d]) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("idle_timeout", d, 32'(q[d].size()), 32'd0);
    endtask

    // Monitor: pop on the first response cycle, then hold the flags to the popped entry until accepted.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rst && rsp_vld[d]) begin
                if (!seen[d]) begin
                    seen[d] = 1;
                    if (q[d].size() == 0) begin
                        chk("unexpected_rsp", d, 32'd1, 32'd0);
                        cur[d].fl = {grt[d], lst[d], equ[d]};
                    end else begin
                        cur[d] = q[d].pop_front();
                        chk("latency", d, 32'(cyc - cur[d].acc), 32'(cur[d].k));
                    end
                end
                chk("flags", d, 32'({grt[d], lst[d], equ[d]}), 32'(cur[d].fl));
                chk("req_rdy_busy", d, 32'(req_rdy[d]), 32'd0);
            end else begin
                seen[d] = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < ND; d++) begin
                rsp_rdy[d] = bp_en[d] ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (hold[d]) rsp_rdy[d] = 1'b0;
            end
        end
    end

    initial begin
        int n;
        int m;
        logic [31:0] v;
        logic [31:0] r;
        cyc    = 0;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        for (int d = 0; d < ND; d++) begin
            req_vld[d] = 1'b0;
            val[d]     = '0;
            rfr[d]     = '0;
            rsp_rdy[d] = 1'b1;
            hold[d]    = 0;
            bp_en[d]   = 0;
            seen[d]    = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("reset_rsp_vld", d, 32'(rsp_vld[d]), 32'd0);
            chk("reset_flags", d, 32'({grt[d], lst[d], equ[d]}), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) chk("reset_req_rdy", d, 32'(req_rdy[d]), 32'd1);

        issue(0, 32'h12345678, 32'h12345677);
        issue(0, 32'h01000000, 32'h02000000);
        issue(0, 32'hFFFFFFFF, 32'h00000001);
        issue(1, 32'hFFFFFFFF, 32'h00000001);
        issue(1, 32'h00000001, 32'hFFFFFFFF);
        issue(2, 32'h000000FF, 32'h00000100);
        wait_idle(0);
        wait_idle(1);
        wait_idle(2);

        // Equal operands with response backpressure.
        hold[0] = 1;
        issue(0, 32'hDEADBEEF, 32'hDEADBEEF);
        n = 0;
        while (!rsp_vld[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_rsp_seen", 0, 32'(rsp_vld[0]), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_rsp_vld", 0, 32'(rsp_vld[0]), 32'd1);
        chk("hold_req_rdy", 0, 32'(req_rdy[0]), 32'd0);
        chk("hold_equ", 0, 32'({grt[0], lst[0], equ[0]}), 32'b001);
        hold[0] = 0;
        n = 0;
        while (rsp_vld[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("release_rsp_vld", 0, 32'(rsp_vld[0]), 32'd0);
        chk("release_req_rdy", 0, 32'(req_rdy[0]), 32'd1);

        // Reset in the middle of a compare discards it.
        issue(0, 32'h12345678, 32'h12345677);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_rsp_vld", 0, 32'(rsp_vld[0]), 32'd0);
        chk("midrst_flags", 0, 32'({grt[0], lst[0], equ[0]}), 32'd0);
        chk("midrst_req_rdy", 0, 32'(req_rdy[0]), 32'd1);
        q[0].delete();
        @(posedge clk); #1;
        rst = 1'b1;
        issue(0, 32'h00000005, 32'h80000000);
        wait_idle(0);

        // Randomized traffic with backpressure, biased toward long equal prefixes.
        for (int d = 0; d < ND; d++) bp_en[d] = 1;
        for (int i = 0; i < 25; i++) begin
            for (int d = 0; d < ND; d++) begin
                v = $urandom;
                m = $urandom_range(0, 3);
                case (m)
                    0:       r = $urandom;
                    1:       r = v;
                    2:       r = v ^ (32'd1 << $urandom_range(0, W[d] - 1));
                    default: r = v ^ (32'd1 << $urandom_range(0, 7));
                endcase
                issue(d, v, r);
            end
        end
        for (int d = 0; d < ND; d++) wait_idle(d);
        for (int d = 0; d < ND; d++) chk("queue_empty", d, 32'(q[d].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
